// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: monitors the scanned seven-segment bus (SEG/AN),
// debounces each digit slot, decodes segment patterns back to hex nibbles
// and presents the reassembled 32-bit display word once all eight digits
// have been seen.
//
// Parameters:
//   SETTLE      - cycles a {AN,SEG} sample must be stable before acceptance
//   TIMEOUT     - idle cycles with a partial frame before it is discarded
// Ports:
//   clk         - clock, rising edge
//   clr         - asynchronous active-high reset
//   SEG[7:0]    - segment lines, active-low (bit0=a .. bit6=g, bit7=dp)
//   AN[7:0]     - digit enables, active-low (AN[i]=0 selects digit i)
//   value[31:0] - last complete decoded frame
//   frame_valid - one-cycle pulse when value updates
//   seen[7:0]   - digit slots captured in the current partial frame
//   bad_digit   - sticky flag, undecodable pattern accepted
//   timeout     - one-cycle pulse when a partial frame is discarded
//   dp[7:0]     - per-digit decimal point, active-high
// Optional feature macro: SEG_DECODE_DP_EN (decimal-point capture into dp).

module seg_scan_decoder #(
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 65536
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [7:0]  SEG,
   input  logic [7:0]  AN,
   output logic [31:0] value,
   output logic        frame_valid,
   output logic [7:0]  seen,
   output logic        bad_digit,
   output logic        timeout,
   output logic [7:0]  dp
);

`ifdef SEG_DECODE_DP_EN
   localparam int SW = 8;
`else
   localparam int SW = 7;
`endif

   localparam int CW = $clog2(SETTLE + 1);
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CMAX  = CW'(SETTLE);
   localparam logic [IW-1:0] ILAST = IW'(TIMEOUT - 1);

   // input stage S and its previous value
   logic [7:0]    s_an_q, p_an_q;
   logic [SW-1:0] s_seg_q, p_seg_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          new_run;

   // latched accepted sample
   logic          acc_q, acc_d;
   logic [7:0]    a_an_q;
   logic [SW-1:0] a_seg_q;

   // frame assembly state
   logic [31:0]   shadow_q, shadow_d;
   logic [31:0]   value_q, value_d;
   logic [7:0]    seen_q, seen_d;
   logic [IW-1:0] idle_q, idle_d;
   logic          fv_q, fv_d;
   logic          to_q, to_d;
   logic          bad_q;

   logic [7:0]    sel;
   logic [4:0]    dec;
   logic          one_hot;
   logic          wr;
   logic          bad_acc;
   logic          done;

   function automatic logic [4:0] seg_dec(input logic [6:0] p);
      logic [4:0] r;
      r = 5'h00;
      case (p)
         7'h40: r = {1'b1, 4'h0};
         7'h79: r = {1'b1, 4'h1};
         7'h24: r = {1'b1, 4'h2};
         7'h30: r = {1'b1, 4'h3};
         7'h19: r = {1'b1, 4'h4};
         7'h12: r = {1'b1, 4'h5};
         7'h02: r = {1'b1, 4'h6};
         7'h78: r = {1'b1, 4'h7};
         7'h00: r = {1'b1, 4'h8};
         7'h10: r = {1'b1, 4'h9};
         7'h08: r = {1'b1, 4'hA};
         7'h03: r = {1'b1, 4'hB};
         7'h46: r = {1'b1, 4'hC};
         7'h21: r = {1'b1, 4'hD};
         7'h06: r = {1'b1, 4'hE};
         7'h0E: r = {1'b1, 4'hF};
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   // Stability counter; acceptance fires once, when the count first hits
   // SETTLE. With SETTLE=1 every new run is accepted on its first cycle.
   always_comb begin
      new_run = (s_an_q != p_an_q) || (s_seg_q != p_seg_q);
      if (new_run)
         cnt_d = CW'(1);
      else if (cnt_q == CMAX)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + CW'(1);
      acc_d = (cnt_d == CMAX) && (new_run || (cnt_q != CMAX));
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s_an_q  <= '0;
         s_seg_q <= '0;
         p_an_q  <= '0;
         p_seg_q <= '0;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         a_an_q  <= '0;
         a_seg_q <= '0;
      end else begin
         s_an_q  <= AN;
         s_seg_q <= SEG[SW-1:0];
         p_an_q  <= s_an_q;
         p_seg_q <= s_seg_q;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         if (acc_d) begin
            a_an_q  <= s_an_q;
            a_seg_q <= s_seg_q;
         end
      end
   end

   always_comb begin
      sel     = ~a_an_q;
      one_hot = $onehot(sel);
      dec     = seg_dec(a_seg_q[6:0]);
      wr      = acc_q && one_hot && dec[4];
      bad_acc = acc_q && one_hot && !dec[4];
      done    = wr && ((seen_q | sel) == 8'hFF);
   end

   always_comb begin
      shadow_d = shadow_q;
      value_d  = value_q;
      seen_d   = seen_q;
      idle_d   = idle_q;
      fv_d     = 1'b0;
      to_d     = 1'b0;
      if (wr) begin
         for (int j = 0; j < 8; j++) begin
            if (sel[j])
               shadow_d[4*j +: 4] = dec[3:0];
         end
         idle_d = '0;
         if (done) begin
            value_d = shadow_d;
            seen_d  = 8'h00;
            fv_d    = 1'b1;
         end else begin
            seen_d  = seen_q | sel;
         end
      end else if (seen_q != 8'h00) begin
         // idle_q counts cycles since the last accept; the step that would
         // bring it to TIMEOUT discards the frame instead
         if (idle_q == ILAST) begin
            seen_d = 8'h00;
            idle_d = '0;
            to_d   = 1'b1;
         end else begin
            idle_d = idle_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         shadow_q <= '0;
         value_q  <= '0;
         seen_q   <= '0;
         idle_q   <= '0;
         fv_q     <= 1'b0;
         to_q     <= 1'b0;
         bad_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         value_q  <= value_d;
         seen_q   <= seen_d;
         idle_q   <= idle_d;
         fv_q     <= fv_d;
         to_q     <= to_d;
         bad_q    <= bad_q | bad_acc;
      end
   end

`ifdef SEG_DECODE_DP_EN
   logic [7:0] sdp_q, sdp_d;
   logic [7:0] dp_q, dp_d;

   always_comb begin
      sdp_d = sdp_q;
      dp_d  = dp_q;
      if (wr) begin
         for (int j = 0; j < 8; j++) begin
            if (sel[j])
               sdp_d[j] = ~a_seg_q[SW-1];
         end
         if (done)
            dp_d = sdp_d;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sdp_q <= '0;
         dp_q  <= '0;
      end else begin
         sdp_q <= sdp_d;
         dp_q  <= dp_d;
      end
   end

   assign dp = dp_q;
`else
   logic unused_dp;
   assign unused_dp = SEG[7];
   assign dp = 8'h00;
`endif

   assign value       = value_q;
   assign frame_valid = fv_q;
   assign seen        = seen_q;
   assign bad_digit   = bad_q;
   assign timeout     = to_q;

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side monitor for the board's multiplexed seven-segment display bus. Samples the scanned `SEG`/`AN` outputs of the CPU top level, debounces each digit slot, and decodes segment patterns back to hex nibbles. When all eight digits have been seen, it presents the reassembled 32-bit display word. It sits in the verification/self-check path beside `top`, so benches and on-board checkers can compare the display against expected register or LED data.

## Interface
Parameters:
- `SETTLE`, 2: number of consecutive cycles a `{AN,SEG}` sample must be held before it is accepted (≥1).
- `TIMEOUT`, 65536: idle cycles with a partial frame before the frame is discarded (≥2).

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `clr` input 1: reset, asynchronous, active-high.
- `SEG` input 8: segment lines, active-low. Bit0=a … bit6=g, bit7=dp.
- `AN` input 8: digit enables, active-low. `AN[i]`=0 selects digit i, which carries `value[4i+3:4i]`.
- `value` output 32: last complete decoded frame.
- `frame_valid` output 1: one-cycle pulse when `value` updates.
- `seen` output 8: digit slots captured in the current partial frame.
- `bad_digit` output 1: sticky; set when an accepted sample has an undecodable pattern.
- `timeout` output 1: one-cycle pulse when a partial frame is discarded.
- `dp` output 8: decimal-point state per digit, active-high (see Configuration).

## Operation
- **Input register:** `SEG` and `AN` are registered once on input (stage S). All decisions use S.
- **Stability counter:**
  - Increments (saturating at `SETTLE`) while S equals its previous value; otherwise it reloads to 1.
  - A sample is *accepted* exactly once per stable run, in the cycle the counter first reaches `SETTLE`.
- **Acceptance qualification:**
  - Accepted only if `AN` has exactly one bit low.
  - `AN`=8'hFF (blank) or more than one bit low: ignored, with no error.
- **Decode:** compares `SEG[6:0]` against the active-low table 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - No match: `bad_digit` is set; the slot is not written and `seen` is unchanged.
- **Valid accept:**
  - The nibble is written into the shadow word at slot i and `seen[i]` is set.
  - Re-accepting a slot already seen overwrites its nibble.
- **Frame completion:** when the write makes `seen`=8'hFF:
  - The shadow word (including the new nibble) is copied to `value`.
  - `frame_valid` pulses and `seen` clears, all on the same edge.
- **Timeout:**
  - The idle counter runs only while `seen`≠0 and reloads to 0 on every valid accept.
  - When it reaches `TIMEOUT`, `seen` is cleared and `timeout` pulses. `value` is retained.
  - A timeout and a completion cannot coincide, because completion requires an accept, which reloads the counter.

## Timing
- **Reset values:** `value`=0, `frame_valid`=0, `seen`=0, `bad_digit`=0, `timeout`=0, `dp`=0. The stability counter, idle counter, shadow word and S are all 0.
- **Reset mid-frame:** discards the partial frame immediately (asynchronous).
- **Latency:** a new `{AN,SEG}` value held from input edge k is accepted at edge k+`SETTLE`. Its `seen` bit, or `frame_valid`/`value` for the final digit, is visible after edge k+`SETTLE`+1.
- **Short holds:** a value held fewer than `SETTLE` cycles is never accepted.
- **Pulse widths:** `frame_valid` and `timeout` are exactly one cycle wide.
- **`bad_digit`:** stays high until `clr`.

## Configuration
- **`SEG_DECODE_DP_EN` defined:**
  - `SEG[7]` is captured with each valid accept into a shadow dp byte, inverted to active-high.
  - The shadow byte is copied to `dp` at frame completion.
  - dp is excluded from decode matching.
- **Not defined:** `SEG[7]` is ignored entirely and `dp` is tied to 0.

## Test plan
- **Full frame:** `SETTLE`=2. Scan `AN`=FE..7F with digits 8,7,6,5,4,3,2,1, holding each 4 cycles (digit 0 first) -> one `frame_valid` pulse, `value`=32'h12345678, `seen` returns to 0, `bad_digit`=0.
- **Glitch rejection:** hold digit 3 pattern `SEG`=8'hB0, `AN`=F7 for 1 cycle, then `AN`=FF -> `seen` stays 0 and no pulse.
- **Bad pattern:** `AN`=FE, `SEG`=8'hFF (all segments off), held 4 cycles -> `bad_digit`=1, `seen[0]`=0. Then a valid full frame of all 0 -> `frame_valid`, `value`=0, `bad_digit` still 1.
- **Timeout:** `TIMEOUT`=16. Accept digits 0–2, then `AN`=FF for 20 cycles -> `timeout` pulses once, 16 cycles after the last accept. `seen`=0 and `value` is unchanged.
- **Reset mid-frame:** accept 5 digits, assert `clr` for 1 cycle, then scan a full frame of F -> `value`=32'hFFFFFFFF and exactly one pulse.
- **DP (with `SEG_DECODE_DP_EN`):** frame with dp low on digits 0 and 7 only -> `dp`=8'h81 at `frame_valid`.
